serial_adder_unit: RTL and testbench

- Multi-cycle bit-serial adder built around one 1-bit full-adder cell plus a carry flip-flop; produces a WIDTH-bit sum and ALU flags.
- Sits directly downstream of the 1-bit full-adder cell: it feeds one operand bit pair and the registered carry into the cell each cycle and consumes `out`/`Cout`.
- Area-cheap alternative to the ripple adder, used by multi-cycle datapath ops such as address or accumulate helpers.

---
 rtl/serial_adder_unit_if.sv | 27 ++
 rtl/serial_adder_unit.sv | 152 +++++++++++++++
 tb/tb_serial_adder_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_unit_if.sv
// Operand/result bundle for serial_adder_unit: request side (start, A, B, sub)
// and the busy/done handshake with result and ALU flags.
interface serial_adder_unit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, A, B, sub,
    input  busy, done, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, A, B, sub,
    output busy, done, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, WIDTH cycles.
// Subtraction is built only when SERIAL_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold the last value
// RUN   | one operand bit pair per cycle through the full-adder cell
// DONE  | one-cycle done pulse; a new start here goes straight back to RUN
module serial_adder_unit #(
  parameter int WIDTH = 64
) (
  input logic                clk,
  input logic                reset,
  serial_adder_unit_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_CIN = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             cin_msb;

  logic [WIDTH-1:0] result_q;
  logic             negative_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_out_q;

  logic             accept;
  logic             busy_c;
  logic             done_c;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;

  // full-adder cell fed by the low operand bits and the carry flop
  always_comb begin
    fa_sum   = sa[0] ^ sb[0] ^ c;
    fa_cout  = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    acc_next = {fa_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa          <= '0;
      sb          <= '0;
      acc         <= '0;
      cnt         <= '0;
      c           <= 1'b0;
      cin_msb     <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.A;
      acc <= '0;
      cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sb  <= bus.sub ? ~bus.B : bus.B;
      c   <= bus.sub;
`else
      sb  <= bus.B;
      c   <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= acc_next;
      c   <= fa_cout;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MSB_CIN) begin
        cin_msb <= fa_cout;
      end
      // visible outputs move only here, so they stay stable through RUN
      if (last_bit) begin
        result_q    <= acc_next;
        negative_q  <= fa_sum;
        zero_q      <= (acc_next == '0);
        carry_out_q <= fa_cout;
        overflow_q  <= cin_msb ^ fa_cout;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: WIDTH=8 vector table, corner sequences and random
// ops against an arithmetic model, plus a WIDTH=64 instance.
module tb_serial_adder_unit;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_adder_unit_if #(.WIDTH(8))  if8 ();
  serial_adder_unit_if #(.WIDTH(64)) if64 ();

  serial_adder_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
  serial_adder_unit #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(if64));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  last_res8  = '0;
  logic [63:0] last_res64 = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] r;
    logic       n;
    logic       z;
    logic       v;
    logic       c;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // plain modular arithmetic with the signed-overflow sign rule
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] r, output logic n, output logic z,
                       output logic v, output logic co);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] bb;
    logic        es;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    es   = s & SUB_EN;
    bb   = es ? (~b & mask) : (b & mask);
    full = {1'b0, a & mask} + {1'b0, bb} + 65'(es);
    r    = full[63:0] & mask;
    co   = full[w];
    n    = r[w-1];
    z    = (r == 64'd0);
    v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
  endtask

  // start in current cycle, checks busy window, returns in the done cycle
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] er, input logic en, input logic ez,
                      input logic ev, input logic ec, input int poke, input string nm);
    int bad;
    if8.start = 1'b1; if8.A = a; if8.B = b; if8.sub = s;
    tick();
    if8.start = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom); if8.sub = ~s;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.result !== last_res8) bad++;
      if (k == poke) begin
        if8.start = 1'b1; if8.A = 8'hAA; if8.B = 8'h11;
      end
      tick();
      if8.start = 1'b0;
    end
    check({nm, ".run_window_bad"}, 64'(bad), 64'd0);
    check({nm, ".done"}, if8.done, 1'b1);
    check({nm, ".busy"}, if8.busy, 1'b0);
    check({nm, ".result"}, if8.result, er);
    check({nm, ".flags_nzvc"}, {if8.negative, if8.zero, if8.overflow, if8.carry_out},
          {en, ez, ev, ec});
    last_res8 = er;
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] er, input logic en, input logic ez,
                       input logic ev, input logic ec, input string nm);
    int bad;
    if64.start = 1'b1; if64.A = a; if64.B = b; if64.sub = s;
    tick();
    if64.start = 1'b0; if64.A = '0; if64.B = '0;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      if (if64.busy !== 1'b1 || if64.done !== 1'b0 || if64.result !== last_res64) bad++;
      tick();
    end
    check({nm, ".run_window_bad"}, 64'(bad), 64'd0);
    check({nm, ".done"}, if64.done, 1'b1);
    check({nm, ".result"}, if64.result, er);
    check({nm, ".flags_nzvc"}, {if64.negative, if64.zero, if64.overflow, if64.carry_out},
          {en, ez, ev, ec});
    last_res64 = er;
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [63:0] mr;
    logic [63:0] wa;
    logic [63:0] wb;
    logic        mn, mz, mv, mc;
    int          bad;

    tbl[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    tbl[4] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'h05, 8'h01, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    tbl[4] = '{8'h05, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h05, 8'h01, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    if8.start = 1'b0;  if8.A = '0;  if8.B = '0;  if8.sub = 1'b0;
    if64.start = 1'b0; if64.A = '0; if64.B = '0; if64.sub = 1'b0;
    reset = 1'b1;
    tick();
    if8.start = 1'b1;
    tick();
    check("reset8.outputs", {if8.busy, if8.done, if8.negative, if8.zero, if8.overflow,
                             if8.carry_out, if8.result}, 64'd0);
    check("reset64.outputs", {if64.busy, if64.done, if64.negative, if64.zero, if64.overflow,
                              if64.carry_out}, 64'd0);
    check("reset64.result", if64.result, 64'd0);
    if8.start = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, tbl[i].n, tbl[i].z, tbl[i].v, tbl[i].c,
           0, $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d.done_one_cycle", i), {if8.done, if8.busy}, 2'b00);
    end

    // start pulsed mid-RUN must be ignored
    run8(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3, "ignore");
    tick();
    check("ignore.back_to_idle", {if8.busy, if8.done}, 2'b00);

    // back-to-back: second start issued in the DONE cycle
    run8(8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 0, "b2b_first");
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 0, "b2b_second");
    for (int k = 0; k < 5; k++) tick();
    check("hold.result", if8.result, 8'h30);

    // reset during RUN aborts without a done pulse
    if8.start = 1'b1; if8.A = 8'h55; if8.B = 8'h11; if8.sub = 1'b0;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("midreset.outputs", {if8.busy, if8.done, if8.negative, if8.zero, if8.overflow,
                               if8.carry_out, if8.result}, 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if8.done !== 1'b0 || if8.busy !== 1'b0) bad++;
    end
    check("midreset.no_done", 64'(bad), 64'd0);
    last_res8 = 8'h00;
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_reset");
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 8'h80; rb = 8'h80; end
      model(8, 64'(ra), 64'(rb), rs, mr, mn, mz, mv, mc);
      run8(ra, rb, rs, mr[7:0], mn, mz, mv, mc, 0, $sformatf("rand8_%0d", i));
      if (i % 3 != 0) tick();
    end

    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, "w64_wrap");
    tick();
    for (int i = 0; i < 3; i++) begin
      wa = {32'($urandom), 32'($urandom)};
      wb = {32'($urandom), 32'($urandom)};
      rs = 1'($urandom_range(0, 1));
      model(64, wa, wb, rs, mr, mn, mz, mv, mc);
      run64(wa, wb, rs, mr, mn, mz, mv, mc, $sformatf("rand64_%0d", i));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
